seq_divider: RTL and testbench

// Iterative radix-2 restoring divider for the CPU execute stage. Produces a quotient
// and remainder from N-bit operands, signed or unsigned per request, one quotient bit
// per clock. It uses valid/ready handshakes on the request and response sides and

---
 rtl/seq_divider_pkg.sv | 22 ++
 rtl/seq_divider_if.sv | 31 +++
 rtl/seq_divider_div_step.sv | 23 ++
 rtl/seq_divider.sv | 173 +++++++++++++++++
 tb/tb_seq_divider.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential divider.
// Provides the FSM state type and two's-complement negate/abs helpers that
// work on a wide word; callers cast back down to their own width.
package cpu_div_pkg;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

  // Widest operand the helpers support; narrower callers zero-extend in and truncate out.
  localparam int unsigned DIV_MAXW = 64;
  typedef logic [DIV_MAXW-1:0] div_word_t;

  // Two's-complement negate; correct modulo 2^W after truncation to any W <= DIV_MAXW.
  function automatic div_word_t neg_n(input div_word_t x);
    return ~x + div_word_t'(1);
  endfunction

  // Magnitude of a value whose sign bit the caller supplies.
  function automatic div_word_t abs_n(input div_word_t x, input logic is_neg);
    return is_neg ? neg_n(x) : x;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle of the sequential divider.
// master: requester/consumer side; slave: divider side.
//   req_valid/req_ready + signed_mode/dividend/divisor : request handshake
//   rsp_valid/rsp_ready + quotient/remainder/flags     : response handshake
//   busy                                               : divider in CALC or DONE
interface seq_divider_if #(
  parameter int unsigned N = 16
);
  logic         req_valid;
  logic         req_ready;
  logic         signed_mode;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;
  logic         busy;

  modport master (
    output req_valid, signed_mode, dividend, divisor, rsp_ready,
    input  req_ready, rsp_valid, quotient, remainder, div_by_zero, overflow, busy
  );

  modport slave (
    input  req_valid, signed_mode, dividend, divisor, rsp_ready,
    output req_ready, rsp_valid, quotient, remainder, div_by_zero, overflow, busy
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step.
//   rem, dvd_msb : partial remainder and the dividend bit shifted in next
//   dvs          : divisor magnitude
//   next_rem     : partial remainder after the trial subtraction
//   q_bit        : quotient bit produced by this step
module div_step #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] rem,
  input  logic         dvd_msb,
  input  logic [N-1:0] dvs,
  output logic [N-1:0] next_rem,
  output logic         q_bit
);
  logic [N:0] shifted;
  logic [N:0] trial;

  // rem < dvs always holds, so the N+1-bit trial never wraps and its MSB is the sign.
  assign shifted  = {rem, dvd_msb};
  assign trial    = shifted - {1'b0, dvs};
  assign q_bit    = ~trial[N];
  assign next_rem = q_bit ? trial[N-1:0] : shifted[N-1:0];
endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
//   clk, rstn : clock and asynchronous active-low reset
//   bus       : slave side of seq_divider_if (request, response, busy)
// Divide-by-zero and signed MIN/-1 bypass the iteration and respond one
// cycle after accept; all other operations take N steps.
module seq_divider
  import cpu_div_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter bit          SIGNED_EN = 1'b1
) (
  input logic          clk,
  input logic          rstn,
  seq_divider_if.slave bus
);
  localparam int unsigned CW      = $clog2(N + 1);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  div_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic          q_neg_q, q_neg_d;
  logic          r_neg_q, r_neg_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rmd_q, rmd_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  step_rem;
  logic [N-1:0]  step_quot;
  logic          step_q;
  logic          sgn, dvd_neg, dvs_neg, accept;

  // Single step reused every CALC cycle; dvd_q doubles as the quotient shift register.
  div_step #(.N(N)) u_step (
    .rem     (rem_q),
    .dvd_msb (dvd_q[N-1]),
    .dvs     (dvs_q),
    .next_rem(step_rem),
    .q_bit   (step_q)
  );

  assign step_quot = {dvd_q[N-2:0], step_q};

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quot_d      = quot_q;
    rmd_d       = rmd_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;

    sgn     = SIGNED_EN && bus.signed_mode;
    dvd_neg = sgn && bus.dividend[N-1];
    dvs_neg = sgn && bus.divisor[N-1];
    accept  = (state_q == DIV_IDLE) && req_ready_q && bus.req_valid;

    case (state_q)
      DIV_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (bus.divisor == '0) begin
            quot_d      = '1;
            rmd_d       = bus.dividend;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = DIV_DONE;
          end else if (sgn && bus.dividend == MIN_VAL && bus.divisor == '1) begin
            quot_d      = MIN_VAL;
            rmd_d       = '0;
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = DIV_DONE;
          end else begin
            rem_d   = '0;
            dvd_d   = N'(abs_n(DIV_MAXW'(bus.dividend), dvd_neg));
            dvs_d   = N'(abs_n(DIV_MAXW'(bus.divisor), dvs_neg));
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            count_d = CW'(N);
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d   = step_rem;
        dvd_d   = step_quot;
        count_d = count_q - CW'(1);
        // Last step: register the sign-corrected result directly.
        if (count_q == CW'(1)) begin
          quot_d      = q_neg_q ? N'(neg_n(DIV_MAXW'(step_quot))) : step_quot;
          rmd_d       = r_neg_q ? N'(neg_n(DIV_MAXW'(step_rem))) : step_rem;
          rsp_valid_d = 1'b1;
          state_d     = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
          busy_d      = 1'b0;
          req_ready_d = 1'b1;
          state_d     = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quot_q      <= '0;
      rmd_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quot_q      <= quot_d;
      rmd_q       <= rmd_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=16): the driver pushes the expected
// response of each accepted request; the monitor checks every cycle the
// response is presented and pops on the response handshake.
module tb_seq_divider;
  localparam int unsigned N = 16;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   hold_low   = 1'b0;
  bit   prev_valid = 1'b0;
  exp_t sbq[$];

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N), .SIGNED_EN(1'b1)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer division (truncating, remainder takes dividend sign).
  function automatic exp_t model(input bit s, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   sa, sd;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = int'(N) + 1;
    e.acc = 0;
    if (b == 16'h0000) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      e.q = 16'h8000; e.r = 16'h0000; e.ovf = 1'b1; e.lat = 1;
    end else if (s) begin
      sa  = int'($signed(a));
      sd  = int'($signed(b));
      e.q = 16'(sa / sd);
      e.r = 16'(sa % sd);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Monitor: drives rsp_ready and checks whatever the DUT presents.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      bus.rsp_ready = 1'b0;
      prev_valid    = 1'b0;
    end else begin
      bus.rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (bus.busy) chk("req_ready_while_busy", 32'(bus.req_ready), 0);
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_rsp_valid", 32'(bus.rsp_valid), 0);
        end else begin
          e = sbq[0];
          if (!prev_valid) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("quotient", 32'(bus.quotient), 32'(e.q));
          chk("remainder", 32'(bus.remainder), 32'(e.r));
          chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
          chk("overflow", 32'(bus.overflow), 32'(e.ovf));
          if (bus.rsp_ready) void'(sbq.pop_front());
        end
      end
      prev_valid = bus.rsp_valid;
    end
  end

  task automatic send(input bit s, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.signed_mode = s;
    bus.dividend    = a;
    bus.divisor     = b;
    bus.req_valid   = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b0;
      return;
    end
    e     = model(s, a, b);
    e.acc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || bus.rsp_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sbq.size()), 0);
  endtask

  function automatic logic [15:0] pick_op();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] a, b;
    int          n;
    rstn            = 1'b1;
    bus.req_valid   = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_quotient", 32'(bus.quotient), 0);
    chk("rst_remainder", 32'(bus.remainder), 0);
    chk("rst_flags", 32'({bus.div_by_zero, bus.overflow}), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset", 32'(bus.req_ready), 1);

    // Directed cases, including exceptions and their priority.
    send(1'b0, 16'd100, 16'd7);
    send(1'b1, 16'hFFF9, 16'h0002);
    send(1'b1, 16'h0007, 16'hFFFE);
    send(1'b0, 16'h1234, 16'h0000);
    send(1'b1, 16'h8000, 16'hFFFF);
    send(1'b0, 16'h8000, 16'hFFFF);
    send(1'b1, 16'h8000, 16'h0000);
    send(1'b1, 16'h0000, 16'h0005);
    send(1'b0, 16'h0000, 16'h0000);
    send(1'b1, 16'h8000, 16'h0002);
    send(1'b1, 16'h8000, 16'h0001);
    send(1'b0, 16'hFFFF, 16'h0001);
    wait_drain();

    // Response held off: outputs stay put and new requests are not taken.
    hold_low = 1'b1;
    send(1'b0, 16'd100, 16'd7);
    n = 0;
    while (!bus.rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_seen", 32'(bus.rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.dividend  = 16'h0BAD;
      bus.divisor   = 16'h0003;
      chk("stall_req_ready", 32'(bus.req_ready), 0);
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 1);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    hold_low      = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);
    chk("ignored_req_not_run", 32'(bus.busy), 0);

    // Reset in the middle of CALC abandons the operation.
    send(1'b0, 16'hABCD, 16'h0013);
    repeat (8) @(posedge clk);
    #1 rstn = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_req_ready", 32'(bus.req_ready), 0);
    chk("midrst_quotient", 32'(bus.quotient), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_rsp", 32'(bus.rsp_valid), 0);
    send(1'b0, 16'hFFFF, 16'h0003);
    wait_drain();

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      a = pick_op();
      b = pick_op();
      send(1'($urandom_range(0, 1)), a, b);
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
